rs_dispatch: RTL and testbench

//  Issue-side producer for the ALU reservation station. Accepts one decoded ALU-class instruction per cycle,

---
 rtl/rs_dispatch_pkg.sv | 40 ++++
 rtl/rs_dispatch_opres.sv | 46 ++++
 rtl/rs_dispatch.sv | 224 ++++++++++++++++++++++
 tb/tb_rs_dispatch.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_dispatch_pkg.sv
// Shared constants and types for the ALU reservation-station dispatch path.
package rs_dispatch_pkg;

    localparam int RS_SIZE = 16;
    localparam int RS_BIT  = 4;
    localparam int ROB_BIT = 4;

    // Credit counter is one bit wider than the RS index so it can hold RS_SIZE.
    localparam logic [RS_BIT:0] CREDIT_MAX = (RS_BIT + 1)'(RS_SIZE);
    localparam logic [RS_BIT:0] CREDIT_ONE = (RS_BIT + 1)'(1);

    // ALU-class op_type encodings, shared with decoder, RS and ALU.
    localparam logic [6:0] OPT_ALU_R = 7'b0110011;
    localparam logic [6:0] OPT_ALU_I = 7'b0010011;
    localparam logic [6:0] OPT_LUI   = 7'b0110111;
    localparam logic [6:0] OPT_AUIPC = 7'b0010111;

    // One issue-bus transaction held in the output register.
    typedef struct packed {
        logic               valid;
        logic [6:0]         op_type;
        logic [2:0]         op;
        logic [31:0]        reg1_v;
        logic [31:0]        reg2_v;
        logic               has_dep1;
        logic               has_dep2;
        logic [ROB_BIT-1:0] rob_entry1;
        logic [ROB_BIT-1:0] rob_entry2;
        logic [ROB_BIT-1:0] rd_rob;
        logic [31:0]        inst;
        logic [31:0]        inst_addr;
    } issue_t;

    // A CDB broadcast carries the value of the given tag.
    function automatic logic cdb_hit(input logic rdy, input logic [ROB_BIT-1:0] ent,
                                     input logic [ROB_BIT-1:0] tag);
        return rdy && (ent == tag);
    endfunction

endpackage

// File: rtl/rs_dispatch_opres.sv
// Single-operand resolver: turns a RAT entry plus regfile, ROB query and
// two CDB sources into either a ready value or a pending ROB tag.
module rs_dispatch_opres
    import rs_dispatch_pkg::*;
(
    input  logic               use_i,
    input  logic [31:0]        alt_value_i,
    input  logic               rat_busy_i,
    input  logic [ROB_BIT-1:0] rat_tag_i,
    input  logic [31:0]        rf_data_i,
    input  logic               rob_ready_i,
    input  logic [31:0]        rob_value_i,
    input  logic               alu_ready_i,
    input  logic [ROB_BIT-1:0] alu_entry_i,
    input  logic [31:0]        alu_value_i,
    input  logic               lsb_ready_i,
    input  logic [ROB_BIT-1:0] lsb_entry_i,
    input  logic [31:0]        lsb_value_i,
    output logic [31:0]        value_o,
    output logic               dep_o,
    output logic [ROB_BIT-1:0] tag_o
);

    // Priority: unused operand, idle RAT, ALU CDB, LSB CDB, ROB query, else wait on tag.
    always_comb begin
        value_o = alt_value_i;
        dep_o   = 1'b0;
        tag_o   = '0;
        if (use_i) begin
            if (!rat_busy_i) begin
                value_o = rf_data_i;
            end else if (cdb_hit(alu_ready_i, alu_entry_i, rat_tag_i)) begin
                value_o = alu_value_i;
            end else if (cdb_hit(lsb_ready_i, lsb_entry_i, rat_tag_i)) begin
                value_o = lsb_value_i;
            end else if (rob_ready_i) begin
                value_o = rob_value_i;
            end else begin
                value_o = '0;
                dep_o   = 1'b1;
                tag_o   = rat_tag_i;
            end
        end
    end

endmodule

// File: rtl/rs_dispatch.sv
// Issue-side producer for the ALU reservation station: renames rd to the ROB
// tail, resolves sources, and drives the RS issue bus from a one-deep register.
// Handshake: the decoder instruction is taken on a cycle where dec_valid_in and
// dec_ready_out are both high; dec_ready_out never depends on dec_valid_in.
module rs_dispatch
    import rs_dispatch_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               rdy_in,
    input  logic               rob_clear_up,
    input  logic               dec_valid_in,
    output logic               dec_ready_out,
    input  logic [6:0]         dec_op_type_in,
    input  logic [2:0]         dec_op_in,
    input  logic [4:0]         dec_rs1_in,
    input  logic [4:0]         dec_rs2_in,
    input  logic [4:0]         dec_rd_in,
    input  logic               dec_use_rs1_in,
    input  logic               dec_use_rs2_in,
    input  logic [31:0]        dec_imm_in,
    input  logic [31:0]        dec_inst_in,
    input  logic [31:0]        dec_inst_addr_in,
    output logic [4:0]         rf_raddr1_out,
    output logic [4:0]         rf_raddr2_out,
    input  logic [31:0]        rf_rdata1_in,
    input  logic [31:0]        rf_rdata2_in,
    input  logic               rob_full_in,
    input  logic [ROB_BIT-1:0] rob_tail_in,
    output logic               rob_alloc_out,
    output logic [ROB_BIT-1:0] rob_q1_entry_out,
    output logic [ROB_BIT-1:0] rob_q2_entry_out,
    input  logic               rob_q1_ready_in,
    input  logic               rob_q2_ready_in,
    input  logic [31:0]        rob_q1_value_in,
    input  logic [31:0]        rob_q2_value_in,
    input  logic               rob_commit_valid_in,
    input  logic [4:0]         rob_commit_rd_in,
    input  logic [ROB_BIT-1:0] rob_commit_entry_in,
    input  logic               alu_ready_in,
    input  logic               lsb_ready_in,
    input  logic [ROB_BIT-1:0] alu_rob_entry_in,
    input  logic [ROB_BIT-1:0] lsb_rob_entry_in,
    input  logic [31:0]        alu_value_in,
    input  logic [31:0]        lsb_value_in,
    input  logic               rs_release_in,
    output logic               issue_signal_out,
    output logic [6:0]         op_type_out,
    output logic [2:0]         op_out,
    output logic [31:0]        reg1_v_out,
    output logic [31:0]        reg2_v_out,
    output logic               has_dep1_out,
    output logic               has_dep2_out,
    output logic [ROB_BIT-1:0] rob_entry1_out,
    output logic [ROB_BIT-1:0] rob_entry2_out,
    output logic [ROB_BIT-1:0] rd_rob_out,
    output logic [31:0]        inst_out,
    output logic [31:0]        inst_addr_out
);

    logic [31:0]               rat_busy_q, rat_busy_d;
    logic [31:0][ROB_BIT-1:0]  rat_tag_q, rat_tag_d;
    logic [RS_BIT:0]           credits_q, credits_d;
    issue_t                    out_q, out_d, out_view;

    logic                      accept;
    logic [31:0]               res1_value, res2_value;
    logic                      res1_dep, res2_dep;
    logic [ROB_BIT-1:0]        res1_tag, res2_tag;

    assign dec_ready_out    = rdy_in && !rob_clear_up && !rob_full_in && (credits_q != '0);
    assign accept           = dec_valid_in && dec_ready_out;
    assign rob_alloc_out    = accept;
    assign rf_raddr1_out    = dec_rs1_in;
    assign rf_raddr2_out    = dec_rs2_in;
    assign rob_q1_entry_out = rat_tag_q[dec_rs1_in];
    assign rob_q2_entry_out = rat_tag_q[dec_rs2_in];

    rs_dispatch_opres u_res1 (
        .use_i       (dec_use_rs1_in),
        .alt_value_i (32'd0),
        .rat_busy_i  (rat_busy_q[dec_rs1_in]),
        .rat_tag_i   (rat_tag_q[dec_rs1_in]),
        .rf_data_i   (rf_rdata1_in),
        .rob_ready_i (rob_q1_ready_in),
        .rob_value_i (rob_q1_value_in),
        .alu_ready_i (alu_ready_in),
        .alu_entry_i (alu_rob_entry_in),
        .alu_value_i (alu_value_in),
        .lsb_ready_i (lsb_ready_in),
        .lsb_entry_i (lsb_rob_entry_in),
        .lsb_value_i (lsb_value_in),
        .value_o     (res1_value),
        .dep_o       (res1_dep),
        .tag_o       (res1_tag)
    );

    rs_dispatch_opres u_res2 (
        .use_i       (dec_use_rs2_in),
        .alt_value_i (dec_imm_in),
        .rat_busy_i  (rat_busy_q[dec_rs2_in]),
        .rat_tag_i   (rat_tag_q[dec_rs2_in]),
        .rf_data_i   (rf_rdata2_in),
        .rob_ready_i (rob_q2_ready_in),
        .rob_value_i (rob_q2_value_in),
        .alu_ready_i (alu_ready_in),
        .alu_entry_i (alu_rob_entry_in),
        .alu_value_i (alu_value_in),
        .lsb_ready_i (lsb_ready_in),
        .lsb_entry_i (lsb_rob_entry_in),
        .lsb_value_i (lsb_value_in),
        .value_o     (res2_value),
        .dep_o       (res2_dep),
        .tag_o       (res2_tag)
    );

    // Patch a pending issue with a CDB broadcast, since the RS only snoops its own busy entries.
    always_comb begin
        out_view = out_q;
        if (out_q.valid && out_q.has_dep1) begin
            if (cdb_hit(alu_ready_in, alu_rob_entry_in, out_q.rob_entry1)) begin
                out_view.reg1_v   = alu_value_in;
                out_view.has_dep1 = 1'b0;
            end else if (cdb_hit(lsb_ready_in, lsb_rob_entry_in, out_q.rob_entry1)) begin
                out_view.reg1_v   = lsb_value_in;
                out_view.has_dep1 = 1'b0;
            end
        end
        if (out_q.valid && out_q.has_dep2) begin
            if (cdb_hit(alu_ready_in, alu_rob_entry_in, out_q.rob_entry2)) begin
                out_view.reg2_v   = alu_value_in;
                out_view.has_dep2 = 1'b0;
            end else if (cdb_hit(lsb_ready_in, lsb_rob_entry_in, out_q.rob_entry2)) begin
                out_view.reg2_v   = lsb_value_in;
                out_view.has_dep2 = 1'b0;
            end
        end
    end

    // Output register next state: patched hold when frozen, load on accept, else drop valid.
    always_comb begin
        out_d = out_view;
        if (rdy_in) begin
            out_d.valid = 1'b0;
            if (accept) begin
                out_d.valid      = 1'b1;
                out_d.op_type    = dec_op_type_in;
                out_d.op         = dec_op_in;
                out_d.reg1_v     = res1_value;
                out_d.reg2_v     = res2_value;
                out_d.has_dep1   = res1_dep;
                out_d.has_dep2   = res2_dep;
                out_d.rob_entry1 = res1_tag;
                out_d.rob_entry2 = res2_tag;
                out_d.rd_rob     = rob_tail_in;
                out_d.inst       = dec_inst_in;
                out_d.inst_addr  = dec_inst_addr_in;
            end
        end
    end

    // RAT next state: flush clears all; commit clears matching tag; rename wins over commit.
    always_comb begin
        rat_busy_d = rat_busy_q;
        rat_tag_d  = rat_tag_q;
        if (rdy_in) begin
            if (rob_clear_up) begin
                rat_busy_d = '0;
            end else begin
                if (rob_commit_valid_in && rat_busy_q[rob_commit_rd_in] &&
                    (rat_tag_q[rob_commit_rd_in] == rob_commit_entry_in)) begin
                    rat_busy_d[rob_commit_rd_in] = 1'b0;
                end
                if (accept && (dec_rd_in != 5'd0)) begin
                    rat_busy_d[dec_rd_in] = 1'b1;
                    rat_tag_d[dec_rd_in]  = rob_tail_in;
                end
            end
        end
    end

    // Credit counter: take one per accept, return one per release, saturate at RS_SIZE.
    always_comb begin
        credits_d = credits_q;
        if (rdy_in) begin
            if (rob_clear_up) begin
                credits_d = CREDIT_MAX;
            end else if (accept && !rs_release_in) begin
                credits_d = credits_q - CREDIT_ONE;
            end else if (!accept && rs_release_in && (credits_q < CREDIT_MAX)) begin
                credits_d = credits_q + CREDIT_ONE;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            rat_busy_q <= '0;
            rat_tag_q  <= '0;
            credits_q  <= CREDIT_MAX;
            out_q      <= '0;
        end else begin
            rat_busy_q <= rat_busy_d;
            rat_tag_q  <= rat_tag_d;
            credits_q  <= credits_d;
            out_q      <= out_d;
        end
    end

    assign issue_signal_out = out_view.valid;
    assign op_type_out      = out_view.op_type;
    assign op_out           = out_view.op;
    assign reg1_v_out       = out_view.reg1_v;
    assign reg2_v_out       = out_view.reg2_v;
    assign has_dep1_out     = out_view.has_dep1;
    assign has_dep2_out     = out_view.has_dep2;
    assign rob_entry1_out   = out_view.rob_entry1;
    assign rob_entry2_out   = out_view.rob_entry2;
    assign rd_rob_out       = out_view.rd_rob;
    assign inst_out         = out_view.inst;
    assign inst_addr_out    = out_view.inst_addr;

endmodule

// File: tb/tb_rs_dispatch.sv
// Directed bench for rs_dispatch: rename, operand resolution, CDB patching,
// commit, flush, stall and credit behaviour with hand-computed expectations.
module tb_rs_dispatch;
  import rs_dispatch_pkg::*;

  logic clk_in = 1'b0;
  logic rst_n_in, rdy_in, rob_clear_up;
  logic dec_valid_in, dec_ready_out;
  logic [6:0] dec_op_type_in;
  logic [2:0] dec_op_in;
  logic [4:0] dec_rs1_in, dec_rs2_in, dec_rd_in;
  logic dec_use_rs1_in, dec_use_rs2_in;
  logic [31:0] dec_imm_in, dec_inst_in, dec_inst_addr_in;
  logic [4:0] rf_raddr1_out, rf_raddr2_out;
  logic [31:0] rf_rdata1_in, rf_rdata2_in;
  logic rob_full_in;
  logic [ROB_BIT-1:0] rob_tail_in;
  logic rob_alloc_out;
  logic [ROB_BIT-1:0] rob_q1_entry_out, rob_q2_entry_out;
  logic rob_q1_ready_in, rob_q2_ready_in;
  logic [31:0] rob_q1_value_in, rob_q2_value_in;
  logic rob_commit_valid_in;
  logic [4:0] rob_commit_rd_in;
  logic [ROB_BIT-1:0] rob_commit_entry_in;
  logic alu_ready_in, lsb_ready_in;
  logic [ROB_BIT-1:0] alu_rob_entry_in, lsb_rob_entry_in;
  logic [31:0] alu_value_in, lsb_value_in;
  logic rs_release_in;
  logic issue_signal_out;
  logic [6:0] op_type_out;
  logic [2:0] op_out;
  logic [31:0] reg1_v_out, reg2_v_out;
  logic has_dep1_out, has_dep2_out;
  logic [ROB_BIT-1:0] rob_entry1_out, rob_entry2_out, rd_rob_out;
  logic [31:0] inst_out, inst_addr_out;

  int checks = 0;
  int errors = 0;

  rs_dispatch dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .rob_clear_up(rob_clear_up),
    .dec_valid_in(dec_valid_in), .dec_ready_out(dec_ready_out),
    .dec_op_type_in(dec_op_type_in), .dec_op_in(dec_op_in),
    .dec_rs1_in(dec_rs1_in), .dec_rs2_in(dec_rs2_in), .dec_rd_in(dec_rd_in),
    .dec_use_rs1_in(dec_use_rs1_in), .dec_use_rs2_in(dec_use_rs2_in),
    .dec_imm_in(dec_imm_in), .dec_inst_in(dec_inst_in), .dec_inst_addr_in(dec_inst_addr_in),
    .rf_raddr1_out(rf_raddr1_out), .rf_raddr2_out(rf_raddr2_out),
    .rf_rdata1_in(rf_rdata1_in), .rf_rdata2_in(rf_rdata2_in),
    .rob_full_in(rob_full_in), .rob_tail_in(rob_tail_in), .rob_alloc_out(rob_alloc_out),
    .rob_q1_entry_out(rob_q1_entry_out), .rob_q2_entry_out(rob_q2_entry_out),
    .rob_q1_ready_in(rob_q1_ready_in), .rob_q2_ready_in(rob_q2_ready_in),
    .rob_q1_value_in(rob_q1_value_in), .rob_q2_value_in(rob_q2_value_in),
    .rob_commit_valid_in(rob_commit_valid_in), .rob_commit_rd_in(rob_commit_rd_in),
    .rob_commit_entry_in(rob_commit_entry_in),
    .alu_ready_in(alu_ready_in), .lsb_ready_in(lsb_ready_in),
    .alu_rob_entry_in(alu_rob_entry_in), .lsb_rob_entry_in(lsb_rob_entry_in),
    .alu_value_in(alu_value_in), .lsb_value_in(lsb_value_in),
    .rs_release_in(rs_release_in),
    .issue_signal_out(issue_signal_out), .op_type_out(op_type_out), .op_out(op_out),
    .reg1_v_out(reg1_v_out), .reg2_v_out(reg2_v_out),
    .has_dep1_out(has_dep1_out), .has_dep2_out(has_dep2_out),
    .rob_entry1_out(rob_entry1_out), .rob_entry2_out(rob_entry2_out), .rd_rob_out(rd_rob_out),
    .inst_out(inst_out), .inst_addr_out(inst_addr_out)
  );

  // Clock
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 ns after the active edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    dec_valid_in = 1'b0;
    alu_ready_in = 1'b0;
    lsb_ready_in = 1'b0;
    rob_q1_ready_in = 1'b0;
    rob_q2_ready_in = 1'b0;
    rob_commit_valid_in = 1'b0;
    rs_release_in = 1'b0;
    rob_clear_up = 1'b0;
  endtask

  task automatic dec(input logic [6:0] opt, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic use1, input logic use2,
                     input logic [31:0] imm, input logic [ROB_BIT-1:0] tail);
    dec_valid_in = 1'b1;
    dec_op_type_in = opt;
    dec_op_in = 3'd0;
    dec_rs1_in = rs1;
    dec_rs2_in = rs2;
    dec_rd_in = rd;
    dec_use_rs1_in = use1;
    dec_use_rs2_in = use2;
    dec_imm_in = imm;
    dec_inst_in = {imm[11:0], rs1, 3'b000, rd, opt};
    dec_inst_addr_in = dec_inst_addr_in + 32'd4;
    rob_tail_in = tail;
  endtask

  initial begin
    rst_n_in = 1'b0;
    rdy_in = 1'b1;
    rob_full_in = 1'b0;
    idle();
    dec_op_type_in = '0; dec_op_in = '0;
    dec_rs1_in = '0; dec_rs2_in = '0; dec_rd_in = '0;
    dec_use_rs1_in = 1'b0; dec_use_rs2_in = 1'b0;
    dec_imm_in = '0; dec_inst_in = '0; dec_inst_addr_in = 32'h0000_0FFC;
    rf_rdata1_in = '0; rf_rdata2_in = '0;
    rob_tail_in = '0;
    rob_q1_value_in = '0; rob_q2_value_in = '0;
    rob_commit_rd_in = '0; rob_commit_entry_in = '0;
    alu_rob_entry_in = '0; lsb_rob_entry_in = '0;
    alu_value_in = '0; lsb_value_in = '0;

    // Reset for one cycle
    step();
    rst_n_in = 1'b1;
    #1;
    chk("rst_issue", issue_signal_out, 0);
    chk("rst_reg2", reg2_v_out, 0);
    chk("rst_rd_rob", rd_rob_out, 0);
    chk("rst_ready", dec_ready_out, 1);

    // addi x1,x0,5 with tail 3
    dec(OPT_ALU_I, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 32'd5, 4'd3);
    #1;
    chk("addi_alloc", rob_alloc_out, 1);
    step();
    // add x2,x1,x1 presented while addi is on the issue bus
    dec(OPT_ALU_R, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1, 32'd0, 4'd4);
    #1;
    chk("addi_issue", issue_signal_out, 1);
    chk("addi_reg1", reg1_v_out, 0);
    chk("addi_reg2", reg2_v_out, 5);
    chk("addi_dep1", has_dep1_out, 0);
    chk("addi_dep2", has_dep2_out, 0);
    chk("addi_rd_rob", rd_rob_out, 3);
    chk("addi_inst", inst_out, 32'h0050_0093);
    chk("addi_optype", op_type_out, OPT_ALU_I);
    chk("rat1_tag_q1", rob_q1_entry_out, 3);
    chk("rat1_tag_q2", rob_q2_entry_out, 3);
    step();
    idle();
    #1;
    chk("add_issue", issue_signal_out, 1);
    chk("add_dep1", has_dep1_out, 1);
    chk("add_dep2", has_dep2_out, 1);
    chk("add_ent1", rob_entry1_out, 3);
    chk("add_ent2", rob_entry2_out, 3);
    chk("add_rd_rob", rd_rob_out, 4);
    // CDB broadcast of tag 3 patches the pending issue in the same cycle
    alu_ready_in = 1'b1; alu_rob_entry_in = 4'd3; alu_value_in = 32'd5;
    #1;
    chk("patch_dep1", has_dep1_out, 0);
    chk("patch_reg1", reg1_v_out, 5);
    chk("patch_dep2", has_dep2_out, 0);
    chk("patch_reg2", reg2_v_out, 5);
    step();
    idle();
    #1;
    chk("no_accept_issue", issue_signal_out, 0);

    // Accept add x2,x1,x1 with tag 3 broadcasting 7; commit tag 3 to x1 same cycle
    dec(OPT_ALU_R, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1, 32'd0, 4'd5);
    alu_ready_in = 1'b1; alu_rob_entry_in = 4'd3; alu_value_in = 32'd7;
    rob_commit_valid_in = 1'b1; rob_commit_rd_in = 5'd1; rob_commit_entry_in = 4'd3;
    step();
    idle();
    #1;
    chk("bypass_dep1", has_dep1_out, 0);
    chk("bypass_reg1", reg1_v_out, 7);
    chk("bypass_dep2", has_dep2_out, 0);
    chk("bypass_reg2", reg2_v_out, 7);
    chk("bypass_rd_rob", rd_rob_out, 5);
    step();

    // Stale commit (tag 4) to x2 must not clear x2, now renamed to tag 5
    rob_commit_valid_in = 1'b1; rob_commit_rd_in = 5'd2; rob_commit_entry_in = 4'd4;
    step();
    idle();
    // add x3,x1,x2: x1 committed (reads regfile), x2 still pending on tag 5
    dec(OPT_ALU_R, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'd0, 4'd6);
    rf_rdata1_in = 32'd11; rf_rdata2_in = 32'hDEAD;
    #1;
    chk("rat2_tag_q2", rob_q2_entry_out, 5);
    step();
    idle();
    #1;
    chk("commit_reg1", reg1_v_out, 11);
    chk("commit_dep1", has_dep1_out, 0);
    chk("stale_dep2", has_dep2_out, 1);
    chk("stale_ent2", rob_entry2_out, 5);
    chk("x3_rd_rob", rd_rob_out, 6);

    // add x4,x2,x0: tag 5 value from ROB query
    dec(OPT_ALU_R, 5'd2, 5'd0, 5'd4, 1'b1, 1'b1, 32'd0, 4'd7);
    rob_q1_ready_in = 1'b1; rob_q1_value_in = 32'd42; rf_rdata2_in = 32'd0;
    step();
    idle();
    #1;
    chk("robq_reg1", reg1_v_out, 42);
    chk("robq_dep1", has_dep1_out, 0);
    chk("robq_reg2", reg2_v_out, 0);

    // add x5,x3,x0: tag 6 value from LSB CDB
    dec(OPT_ALU_R, 5'd3, 5'd0, 5'd5, 1'b1, 1'b1, 32'd0, 4'd8);
    lsb_ready_in = 1'b1; lsb_rob_entry_in = 4'd6; lsb_value_in = 32'd99;
    step();
    idle();
    #1;
    chk("lsb_reg1", reg1_v_out, 99);
    chk("lsb_dep1", has_dep1_out, 0);

    // Freeze with rdy_in low: issue held, decoder blocked
    dec(OPT_ALU_I, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 32'h123, 4'd9);
    step();
    idle();
    rdy_in = 1'b0;
    dec_valid_in = 1'b1;
    #1;
    chk("frz_ready", dec_ready_out, 0);
    chk("frz_alloc", rob_alloc_out, 0);
    step();
    chk("frz_issue", issue_signal_out, 1);
    chk("frz_reg2", reg2_v_out, 32'h123);
    chk("frz_rd_rob", rd_rob_out, 9);
    dec_valid_in = 1'b0;
    rdy_in = 1'b1;
    step();
    chk("unfrz_issue", issue_signal_out, 0);

    // ROB full blocks the decoder
    rob_full_in = 1'b1;
    #1;
    chk("robfull_ready", dec_ready_out, 0);
    rob_full_in = 1'b0;

    // Flush: x1 renamed then cleared, pending issue dropped
    dec(OPT_ALU_I, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 32'd1, 4'd10);
    step();
    idle();
    rob_clear_up = 1'b1;
    dec_valid_in = 1'b1;
    #1;
    chk("flush_ready", dec_ready_out, 0);
    chk("flush_alloc", rob_alloc_out, 0);
    step();
    idle();
    #1;
    chk("flush_issue", issue_signal_out, 0);
    dec(OPT_ALU_R, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 32'd0, 4'd11);
    rf_rdata1_in = 32'd9; rf_rdata2_in = 32'd0;
    step();
    idle();
    #1;
    chk("postflush_issue", issue_signal_out, 1);
    chk("postflush_reg1", reg1_v_out, 9);
    chk("postflush_dep1", has_dep1_out, 0);

    // Credits: refill by flush, release at full must saturate, then drain
    rob_clear_up = 1'b1;
    step();
    idle();
    rs_release_in = 1'b1;
    step();
    rs_release_in = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      dec(OPT_ALU_I, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'(i), 4'(i));
      #1;
      chk("burst_alloc", rob_alloc_out, 1);
      step();
    end
    idle();
    #1;
    chk("empty_ready", dec_ready_out, 0);
    dec_valid_in = 1'b1;
    #1;
    chk("empty_alloc", rob_alloc_out, 0);
    idle();
    rs_release_in = 1'b1;
    step();
    idle();
    #1;
    chk("release_ready", dec_ready_out, 1);
    dec(OPT_ALU_I, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'd0, 4'd0);
    rs_release_in = 1'b1;
    step();
    idle();
    #1;
    chk("acc_rel_ready", dec_ready_out, 1);
    dec(OPT_ALU_I, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'd0, 4'd1);
    step();
    idle();
    #1;
    chk("last_credit_ready", dec_ready_out, 0);

    // Reset while an issue is pending
    rs_release_in = 1'b1;
    step();
    idle();
    dec(OPT_ALU_I, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 32'h55, 4'd12);
    step();
    idle();
    rst_n_in = 1'b0;
    step();
    rst_n_in = 1'b1;
    #1;
    chk("rst2_issue", issue_signal_out, 0);
    chk("rst2_rd_rob", rd_rob_out, 0);
    chk("rst2_reg2", reg2_v_out, 0);
    chk("rst2_ready", dec_ready_out, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
